pp_row_streamer: RTL and testbench

- Parametrised sequential successor to the team's 8x8 combinational partial-product generator.
- Accepts one W x W operand pair through a valid/ready handshake and emits the W shifted partial-product rows, each 2W bits wide, one row per accepted beat on a valid/ready output stream.
- Adds a per-transaction signed (two's complement) mode and an optional zero-row skip.
- Feeds a downstream sequential accumulator or compressor tree so that row generation is decoupled from reduction.

---
 rtl/pp_row_streamer.sv | 142 ++++++++++++++
 tb/tb_pp_row_streamer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_row_streamer.sv
// pp_row_streamer: streams the W shifted partial-product rows of one A x B
// operand pair, one row per valid/ready beat, unsigned or two's complement.
module pp_row_streamer #(
  parameter int  W         = 8,
  parameter bit  SKIP_ZERO = 1'b0,
  localparam int IW        = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_signed,
  output logic            pp_valid,
  input  logic            pp_ready,
  output logic [2*W-1:0]  pp_row,
  output logic [IW-1:0]   pp_idx,
  output logic            pp_last,
  output logic            busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_signed;
  logic [IW-1:0]    r_idx;
  logic [W-1:0]     w_a_nxt;
  logic [W-1:0]     w_b_nxt;
  logic             w_signed_nxt;
  logic [IW-1:0]    w_idx_nxt;

  logic [W-1:0]     w_hi_b;
  logic [IW-1:0]    w_first;
  logic [IW-1:0]    w_next;
  logic             w_last;
  logic [2*W-1:0]   w_a_ext;
  logic [2*W-1:0]   w_shift;
  logic [2*W-1:0]   w_row;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IW-1:0] f_lsb(
    input logic [W-1:0] v
  );
    logic [IW-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Multiplier bits strictly above the current row.
  always_comb begin
    w_hi_b = '0;
    for (int i = 0; i < W; i++) begin
      w_hi_b[i] = r_b[i] & (i > int'(r_idx));
    end
  end

  assign w_first = SKIP_ZERO ? f_lsb(in_b) : '0;
  assign w_next  = SKIP_ZERO ? f_lsb(w_hi_b)
                             : r_idx + IW'(1);
  assign w_last  = SKIP_ZERO ? (w_hi_b == '0)
                             : (r_idx == IW'(W - 1));

  assign w_a_ext = r_signed ? {{W{r_a[W-1]}}, r_a}
                            : {{W{1'b0}}, r_a};
  assign w_shift = w_a_ext << r_idx;

  // The signed top row carries negative weight.
  always_comb begin
    w_row = '0;
    if (r_b[r_idx]) begin
      if (r_signed && (r_idx == IW'(W - 1)))
        w_row = -w_shift;
      else
        w_row = w_shift;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_signed_nxt = r_signed;
    w_idx_nxt    = r_idx;
    in_ready     = 1'b0;
    pp_valid     = 1'b0;
    busy         = 1'b0;
    pp_row       = '0;
    pp_idx       = '0;
    pp_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_a_nxt      = in_a;
          w_b_nxt      = in_b;
          w_signed_nxt = in_signed;
          w_idx_nxt    = w_first;
          w_state_nxt  = S_EMIT;
        end
      end
      S_EMIT: begin
        pp_valid = 1'b1;
        busy     = 1'b1;
        pp_row   = w_row;
        pp_idx   = r_idx;
        pp_last  = w_last;
        if (pp_ready) begin
          if (w_last) w_state_nxt = S_IDLE;
          else        w_idx_nxt   = w_next;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_signed <= w_signed_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

endmodule

// File: tb/tb_pp_row_streamer.sv
// tb_pp_row_streamer: three instances (W=8, W=8 skip-zero, W=4) checked
// against an arithmetic row/product model.
module tb_pp_row_streamer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  vld;
  logic [7:0]  ina, inb;
  logic        sgn, rdy;

  logic        r8, v8, l8, b8;
  logic [15:0] row8;
  logic [2:0]  idx8;
  logic        rs, vs, ls, bs;
  logic [15:0] rows;
  logic [2:0]  idxs;
  logic        r4, v4, l4, b4;
  logic [7:0]  row4;
  logic [1:0]  idx4;

  pp_row_streamer #(.W(8), .SKIP_ZERO(1'b0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(r8),
    .in_a(ina), .in_b(inb), .in_signed(sgn), .pp_valid(v8),
    .pp_ready(rdy), .pp_row(row8), .pp_idx(idx8), .pp_last(l8),
    .busy(b8));

  pp_row_streamer #(.W(8), .SKIP_ZERO(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rs),
    .in_a(ina), .in_b(inb), .in_signed(sgn), .pp_valid(vs),
    .pp_ready(rdy), .pp_row(rows), .pp_idx(idxs), .pp_last(ls),
    .busy(bs));

  pp_row_streamer #(.W(4), .SKIP_ZERO(1'b0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(r4),
    .in_a(ina[3:0]), .in_b(inb[3:0]), .in_signed(sgn), .pp_valid(v4),
    .pp_ready(rdy), .pp_row(row4), .pp_idx(idx4), .pp_last(l4),
    .busy(b4));

  int          sel;
  logic        c_rdy, c_val, c_last, c_busy;
  logic [15:0] c_row;
  logic [2:0]  c_idx;

  always_comb begin
    case (sel)
      0: begin
        c_rdy = r8; c_val = v8; c_last = l8; c_busy = b8;
        c_row = row8; c_idx = idx8;
      end
      1: begin
        c_rdy = rs; c_val = vs; c_last = ls; c_busy = bs;
        c_row = rows; c_idx = idxs;
      end
      default: begin
        c_rdy = r4; c_val = v4; c_last = l4; c_busy = b4;
        c_row = {8'h00, row4}; c_idx = {1'b0, idx4};
      end
    endcase
  end

  int     vec, errs;
  longint exp_row[$], obs_row[$];
  int     exp_idx[$], obs_idx[$], obs_cyc[$];
  bit     exp_last[$], obs_last[$];
  longint exp_prod, modv;
  bit     tmo, rdy_after;

  function automatic longint modp(input longint x, input longint m);
    return ((x % m) + m) % m;
  endfunction

  // Reference rows straight from the arithmetic definition.
  task automatic build_exp();
    int w;
    longint sa, sb, t;
    w = (sel == 2) ? 4 : 8;
    modv = longint'(1) << (2 * w);
    exp_row.delete(); exp_idx.delete(); exp_last.delete();
    sa = longint'(ina) & ((longint'(1) << w) - 1);
    sb = longint'(inb) & ((longint'(1) << w) - 1);
    if (sgn && sa >= (longint'(1) << (w - 1))) sa -= longint'(1) << w;
    if (sgn && sb >= (longint'(1) << (w - 1))) sb -= longint'(1) << w;
    exp_prod = modp(sa * sb, modv);
    for (int i = 0; i < w; i++) begin
      if (sel == 1 && !inb[i]) continue;
      t = 0;
      if (inb[i]) begin
        t = sa * (longint'(1) << i);
        if (sgn && i == w - 1) t = -t;
      end
      exp_row.push_back(modp(t, modv));
      exp_idx.push_back(i);
      exp_last.push_back(1'b0);
    end
    if (exp_idx.size() == 0) begin
      exp_row.push_back(0); exp_idx.push_back(0); exp_last.push_back(1'b0);
    end
    exp_last[exp_last.size() - 1] = 1'b1;
  endtask

  // Drives one transaction and records every handshaken row.
  task automatic collect(input bit rr);
    int cyc;
    bit done;
    obs_row.delete(); obs_idx.delete(); obs_last.delete(); obs_cyc.delete();
    @(posedge clk); #1;
    vld[sel] = 1'b1;
    rdy = rr ? 1'($urandom % 2) : 1'b1;
    @(posedge clk); #1;
    vld = '0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      cyc++;
      @(negedge clk);
      if (c_val && rdy) begin
        obs_row.push_back(longint'(c_row));
        obs_idx.push_back(int'(c_idx));
        obs_last.push_back(c_last);
        obs_cyc.push_back(cyc);
        if (c_last) done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) rdy = rr ? 1'($urandom % 2) : 1'b1;
    end
    tmo = !done;
    rdy = 1'b1;
    @(negedge clk);
    rdy_after = c_rdy;
  endtask

  task automatic test_reset();
    #2;
    vec++;
    if ({r8, v8, row8, idx8, l8, b8} !== {1'b1, 1'b0, 16'h0, 3'h0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_d8: got rdy=%0b val=%0b row=%h idx=%0d last=%0b busy=%0b",
               r8, v8, row8, idx8, l8, b8);
    end
    vec++;
    if ({rs, vs, bs, r4, v4, b4} !== 6'b100100) begin
      errs++;
      $display("FAIL reset_others: got %b want 100100", {rs, vs, bs, r4, v4, b4});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_unsigned();
    longint s;
    sel = 0; ina = 8'hB5; inb = 8'h03; sgn = 1'b0;
    build_exp(); collect(1'b0);
    vec++;
    if (tmo || obs_idx.size() != exp_idx.size()) begin
      errs++;
      $display("FAIL uns_count: got %0d rows (timeout=%0b) want %0d", obs_idx.size(), tmo, exp_idx.size());
    end
    s = 0;
    for (int k = 0; k < obs_idx.size() && k < exp_idx.size(); k++) begin
      s += obs_row[k];
      vec++;
      if (obs_idx[k] !== exp_idx[k] || obs_row[k] !== exp_row[k] ||
          obs_last[k] !== exp_last[k] || obs_cyc[k] !== k + 1) begin
        errs++;
        $display("FAIL uns_row%0d: got idx=%0d row=%h last=%0b cyc=%0d want idx=%0d row=%h last=%0b cyc=%0d",
                 k, obs_idx[k], obs_row[k], obs_last[k], obs_cyc[k],
                 exp_idx[k], exp_row[k], exp_last[k], k + 1);
      end
    end
    vec++;
    if (modp(s, modv) !== 64'h021F || rdy_after !== 1'b1) begin
      errs++;
      $display("FAIL uns_sum: got sum=%h in_ready=%0b want 021f 1", modp(s, modv), rdy_after);
    end
  endtask

  task automatic test_signed();
    longint s;
    logic [7:0] ta [2];
    logic [7:0] tb [2];
    longint ts [2];
    ta[0] = 8'hFF; tb[0] = 8'h80; ts[0] = 64'h0080;
    ta[1] = 8'h80; tb[1] = 8'h01; ts[1] = 64'hFF80;
    for (int t = 0; t < 2; t++) begin
      sel = 0; ina = ta[t]; inb = tb[t]; sgn = 1'b1;
      build_exp(); collect(1'b0);
      vec++;
      if (tmo || obs_idx.size() != exp_idx.size()) begin
        errs++;
        $display("FAIL sgn%0d_count: got %0d want %0d", t, obs_idx.size(), exp_idx.size());
      end
      s = 0;
      for (int k = 0; k < obs_idx.size() && k < exp_idx.size(); k++) begin
        s += obs_row[k];
        vec++;
        if (obs_idx[k] !== exp_idx[k] || obs_row[k] !== exp_row[k] || obs_last[k] !== exp_last[k]) begin
          errs++;
          $display("FAIL sgn%0d_row%0d: got idx=%0d row=%h last=%0b want idx=%0d row=%h last=%0b",
                   t, k, obs_idx[k], obs_row[k], obs_last[k], exp_idx[k], exp_row[k], exp_last[k]);
        end
      end
      vec++;
      if (modp(s, modv) !== ts[t] || exp_prod !== ts[t]) begin
        errs++;
        $display("FAIL sgn%0d_sum: got %h (model %h) want %h", t, modp(s, modv), exp_prod, ts[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n, k;
    sel = 0; ina = 8'hB5; inb = 8'h07; sgn = 1'b0; rdy = 1'b1;
    @(posedge clk); #1; vld[0] = 1'b1;
    @(posedge clk); #1; vld[0] = 1'b0;
    n = 0;
    while (c_idx != 3'd2 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    rdy = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      vec++;
      if ({c_val, c_row, c_idx, c_last, c_rdy} !== {1'b1, 16'h02D4, 3'd2, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL bp_hold%0d: got val=%0b row=%h idx=%0d last=%0b rdy=%0b want 1 02d4 2 0 0",
                 h, c_val, c_row, c_idx, c_last, c_rdy);
      end
      @(posedge clk); #1;
      vld[0] = (h == 1); ina = 8'hFF;
    end
    vld[0] = 1'b0; rdy = 1'b1;
    k = 2; n = 0;
    while (n < 20) begin
      @(negedge clk);
      vec++;
      if (c_val !== 1'b1 || int'(c_idx) !== k ||
          c_row !== ((k < 3) ? 16'(16'h00B5 << k) : 16'h0) || c_last !== (k == 7)) begin
        errs++;
        $display("FAIL bp_drain%0d: got val=%0b idx=%0d row=%h last=%0b", k, c_val, c_idx, c_row, c_last);
      end
      if (c_last || !c_val) break;
      k++; n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if (c_val !== 1'b0 || c_rdy !== 1'b1) begin
      errs++;
      $display("FAIL bp_after: got val=%0b rdy=%0b want 0 1", c_val, c_rdy);
    end
  endtask

  task automatic test_back_to_back();
    sel = 0; ina = 8'h11; inb = 8'hFF; sgn = 1'b0; rdy = 1'b1;
    @(posedge clk); #1; vld[0] = 1'b1;
    @(posedge clk); #1; vld[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    vec++;
    if (c_idx !== 3'd7 || c_last !== 1'b1) begin
      errs++;
      $display("FAIL b2b_last: got idx=%0d last=%0b want 7 1", c_idx, c_last);
    end
    vld[0] = 1'b1; ina = 8'h22; inb = 8'h01;
    @(posedge clk); #1;
    vec++;
    if (c_rdy !== 1'b1 || c_val !== 1'b0) begin
      errs++;
      $display("FAIL b2b_gap: got rdy=%0b val=%0b want 1 0", c_rdy, c_val);
    end
    @(posedge clk); #1;
    vld[0] = 1'b0;
    vec++;
    if (c_val !== 1'b1 || c_idx !== 3'd0 || c_row !== 16'h0022 || c_rdy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_second: got val=%0b idx=%0d row=%h rdy=%0b want 1 0 0022 0",
               c_val, c_idx, c_row, c_rdy);
    end
    repeat (8) @(posedge clk);
    #1;
    vec++;
    if (c_val !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end: got val=%0b want 0", c_val);
    end
  endtask

  task automatic test_skip();
    logic [7:0] tb [2];
    tb[0] = 8'h05; tb[1] = 8'h00;
    for (int t = 0; t < 2; t++) begin
      sel = 1; ina = 8'h0F; inb = tb[t]; sgn = 1'b0;
      build_exp(); collect(1'b0);
      vec++;
      if (tmo || obs_idx.size() != ((t == 0) ? 2 : 1) || exp_idx.size() != obs_idx.size()) begin
        errs++;
        $display("FAIL skip%0d_count: got %0d want %0d", t, obs_idx.size(), (t == 0) ? 2 : 1);
      end
      for (int k = 0; k < obs_idx.size() && k < exp_idx.size(); k++) begin
        vec++;
        if (obs_idx[k] !== exp_idx[k] || obs_row[k] !== exp_row[k] ||
            obs_last[k] !== exp_last[k] || obs_cyc[k] !== k + 1) begin
          errs++;
          $display("FAIL skip%0d_row%0d: got idx=%0d row=%h last=%0b want idx=%0d row=%h last=%0b",
                   t, k, obs_idx[k], obs_row[k], obs_last[k], exp_idx[k], exp_row[k], exp_last[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0; ina = 8'hB5; inb = 8'hFF; sgn = 1'b0; rdy = 1'b1;
    @(posedge clk); #1; vld[0] = 1'b1;
    @(posedge clk); #1; vld[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (c_idx !== 3'd4) begin
      errs++;
      $display("FAIL rstmid_pos: got idx=%0d want 4", c_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({v8, b8, r8, l8} !== 4'b0010) begin
      errs++;
      $display("FAIL rstmid_abort: got val=%0b busy=%0b rdy=%0b last=%0b want 0 0 1 0", v8, b8, r8, l8);
    end
    @(negedge clk); rst_n = 1'b1;
    ina = 8'h02; inb = 8'h02;
    build_exp(); collect(1'b0);
    vec++;
    if (tmo || obs_idx.size() != 8 || obs_row[1] !== 64'h0004 || obs_row[0] !== 0 ||
        obs_row[7] !== 0 || obs_row != exp_row) begin
      errs++;
      $display("FAIL rstmid_after: got %0d rows timeout=%0b", obs_idx.size(), tmo);
    end
  endtask

  task automatic test_random();
    bit ok;
    longint s;
    int nt;
    for (int m = 0; m < 3; m++) begin
      nt = (m == 2) ? 512 : 40;
      for (int t = 0; t < nt; t++) begin
        sel = m;
        if (m == 2) begin
          ina = 8'(t % 16); inb = 8'((t / 16) % 16); sgn = 1'(t / 256);
        end else begin
          ina = 8'($urandom); inb = 8'($urandom); sgn = 1'($urandom % 2);
        end
        build_exp(); collect(1'b1);
        ok = !tmo && obs_idx.size() == exp_idx.size();
        s = 0;
        for (int k = 0; ok && k < obs_idx.size(); k++) begin
          s += obs_row[k];
          if (obs_idx[k] !== exp_idx[k] || obs_row[k] !== exp_row[k] || obs_last[k] !== exp_last[k])
            ok = 1'b0;
        end
        vec++;
        if (!ok) begin
          errs++;
          $display("FAIL rand_rows m%0d a=%h b=%h s=%0b: got %0d rows timeout=%0b want %0d",
                   m, ina, inb, sgn, obs_idx.size(), tmo, exp_idx.size());
        end
        vec++;
        if (modp(s, modv) !== exp_prod) begin
          errs++;
          $display("FAIL rand_sum m%0d a=%h b=%h s=%0b: got %h want %h",
                   m, ina, inb, sgn, modp(s, modv), exp_prod);
        end
      end
    end
  endtask

  initial begin
    vec = 0; errs = 0; sel = 0;
    vld = '0; ina = '0; inb = '0; sgn = 1'b0; rdy = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_skip();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
